sdrc_app_pack: RTL and testbench



---
 rtl/sdrc_app_pkg.sv | 19 +
 rtl/sdrc_sync_fifo.sv | 41 ++++
 rtl/sdrc_app_pack.sv | 150 +++++++++++++++
 tb/tb_sdrc_app_pack.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_app_pkg.sv
// Shared width codes and ratio helper for the SDRAM application-side width adapter.
package sdrc_app_pkg;

  typedef enum logic [1:0] {
    W32 = 2'b00,
    W16 = 2'b01,
    W8  = 2'b10
  } width_e;

  // Returns beats-per-word minus one; codes 1x all mean 8-bit host.
  function automatic logic [1:0] ratio_m1(input logic [1:0] w);
    logic [1:0] r;
    r = 2'd3;
    if (w == W32) r = 2'd0;
    else if (w == W16) r = 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/sdrc_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module sdrc_sync_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdrc_app_pack.sv
// Packs narrow host write beats into 32-bit app words and unpacks 32-bit app read words into host beats.
module sdrc_app_pack
  import sdrc_app_pkg::*;
#(
  parameter int APP_DW   = 32,
  parameter int APP_BW   = 4,
  parameter int WR_DEPTH = 2,
  parameter int RD_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        host_width,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [APP_DW-1:0] host_wr_data,
  input  logic [APP_BW-1:0] host_wr_en_n,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  output logic              wr_word_avail,
  input  logic              app_wr_next,
  input  logic [APP_DW-1:0] app_rd_data,
  input  logic              app_rd_valid,
  input  logic              app_last_rd,
  output logic              host_rd_valid,
  input  logic              host_rd_ready,
  output logic [APP_DW-1:0] host_rd_data,
  output logic              host_rd_last,
  output logic              wr_udf,
  output logic              rd_ovf
);
  logic [1:0]        width_q, r_m1;
  logic              width_chg;
  logic [1:0]        wr_beat_q, wr_beat_d, wr_beat_cur;
  logic [1:0]        rd_beat_q, rd_beat_d, rd_beat_cur;
  logic [APP_DW-1:0] asm_data_q, asm_data_d, base_data, lane_data, word_data;
  logic [APP_BW-1:0] asm_en_q, asm_en_d, base_en, lane_en, lane_mask, word_en;
  logic              wr_acc, wr_push, wr_full, wr_empty;
  logic [APP_BW+APP_DW-1:0] wr_head;
  logic              rd_full, rd_empty, rd_pop, rd_hs, rd_at_last;
  logic [APP_DW:0]   rd_head;
  logic              wr_udf_q, rd_ovf_q;

  // A width change takes effect in the same cycle: counters and partial word act as cleared.
  assign width_chg   = (host_width != width_q);
  assign r_m1        = ratio_m1(host_width);
  assign wr_beat_cur = width_chg ? 2'd0 : wr_beat_q;
  assign rd_beat_cur = width_chg ? 2'd0 : rd_beat_q;
  assign base_data   = width_chg ? '0 : asm_data_q;
  assign base_en     = width_chg ? '1 : asm_en_q;

  always_comb begin
    lane_mask = '1;
    lane_data = host_wr_data;
    lane_en   = host_wr_en_n;
    if (r_m1 == 2'd1) begin
      lane_mask = wr_beat_cur[0] ? 4'b1100 : 4'b0011;
      lane_data = {2{host_wr_data[15:0]}};
      lane_en   = {2{host_wr_en_n[1:0]}};
    end else if (r_m1 == 2'd3) begin
      lane_mask = 4'b0001 << wr_beat_cur;
      lane_data = {4{host_wr_data[7:0]}};
      lane_en   = {4{host_wr_en_n[0]}};
    end
  end

  for (genvar gi = 0; gi < APP_BW; gi++) begin : g_lane
    assign word_data[gi*8 +: 8] = lane_mask[gi] ? lane_data[gi*8 +: 8] : base_data[gi*8 +: 8];
    assign word_en[gi]          = lane_mask[gi] ? lane_en[gi] : base_en[gi];
  end

  always_comb begin
    wr_acc     = host_wr_valid & ~wr_full;
    wr_push    = wr_acc & (wr_beat_cur == r_m1);
    wr_beat_d  = wr_beat_cur;
    asm_data_d = base_data;
    asm_en_d   = base_en;
    if (wr_acc) begin
      wr_beat_d  = wr_push ? 2'd0 : wr_beat_cur + 2'd1;
      asm_data_d = word_data;
      asm_en_d   = word_en;
    end
  end

  sdrc_sync_fifo #(.W(APP_BW + APP_DW), .DEPTH(WR_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_push),
    .pop   (app_wr_next),
    .din   ({word_en, word_data}),
    .dout  (wr_head),
    .full  (wr_full),
    .empty (wr_empty)
  );

  assign host_wr_ready = ~wr_full;
  assign wr_word_avail = ~wr_empty;
  assign app_wr_data   = wr_head[APP_DW-1:0];
  assign app_wr_en_n   = wr_empty ? '1 : wr_head[APP_BW+APP_DW-1:APP_DW];

  assign rd_hs      = ~rd_empty & host_rd_ready;
  assign rd_at_last = (rd_beat_cur == r_m1);
  assign rd_pop     = rd_hs & rd_at_last;

  sdrc_sync_fifo #(.W(APP_DW + 1), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (app_rd_valid),
    .pop   (rd_pop),
    .din   ({app_last_rd, app_rd_data}),
    .dout  (rd_head),
    .full  (rd_full),
    .empty (rd_empty)
  );

  always_comb begin
    host_rd_data = rd_head[APP_DW-1:0];
    if (r_m1 == 2'd1)
      host_rd_data = {16'h0, rd_beat_cur[0] ? rd_head[31:16] : rd_head[15:0]};
    else if (r_m1 == 2'd3)
      host_rd_data = {24'h0, rd_head[rd_beat_cur*8 +: 8]};
    rd_beat_d = rd_beat_cur;
    if (rd_hs) rd_beat_d = rd_at_last ? 2'd0 : rd_beat_cur + 2'd1;
  end

  assign host_rd_valid = ~rd_empty;
  assign host_rd_last  = ~rd_empty & rd_head[APP_DW] & rd_at_last;
  assign wr_udf        = wr_udf_q;
  assign rd_ovf        = rd_ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q    <= W32;
      wr_beat_q  <= '0;
      rd_beat_q  <= '0;
      asm_data_q <= '0;
      asm_en_q   <= '1;
      wr_udf_q   <= 1'b0;
      rd_ovf_q   <= 1'b0;
    end else begin
      width_q    <= host_width;
      wr_beat_q  <= wr_beat_d;
      rd_beat_q  <= rd_beat_d;
      asm_data_q <= asm_data_d;
      asm_en_q   <= asm_en_d;
      if (app_wr_next & wr_empty)            wr_udf_q <= 1'b1;
      if (app_rd_valid & rd_full & ~rd_pop)  rd_ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdrc_app_pack.sv
// Scoreboard bench for sdrc_app_pack: directed stimulus queues expected words/beats, monitors compare.
module tb_sdrc_app_pack;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  host_width;
  logic        host_wr_valid, host_wr_ready;
  logic [31:0] host_wr_data;
  logic [3:0]  host_wr_en_n;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        wr_word_avail, app_wr_next;
  logic [31:0] app_rd_data;
  logic        app_rd_valid, app_last_rd;
  logic        host_rd_valid, host_rd_ready;
  logic [31:0] host_rd_data;
  logic        host_rd_last, wr_udf, rd_ovf;

  int tests = 0;
  int fails = 0;
  logic [35:0] wq[$];
  logic [32:0] rq[$];

  sdrc_app_pack #(.APP_DW(32), .APP_BW(4), .WR_DEPTH(2), .RD_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .host_width(host_width),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_data(host_wr_data), .host_wr_en_n(host_wr_en_n),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .wr_word_avail(wr_word_avail), .app_wr_next(app_wr_next),
    .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .host_rd_data(host_rd_data), .host_rd_last(host_rd_last),
    .wr_udf(wr_udf), .rd_ovf(rd_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else
      $display("[TB] ok   %s = 0x%0h", name, act);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic [3:0] en);
    int  n;
    logic rdy;
    n = 0;
    host_wr_valid = 1'b1;
    host_wr_data  = d;
    host_wr_en_n  = en;
    do begin
      rdy = host_wr_ready;
      step();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL wr_timeout: beat 0x%0h not accepted, ready=%0b required 1", d, rdy);
    end
    host_wr_valid = 1'b0;
  endtask

  task automatic rd_word(input logic [31:0] d, input logic last);
    app_rd_valid = 1'b1;
    app_rd_data  = d;
    app_last_rd  = last;
    step();
    app_rd_valid = 1'b0;
    app_last_rd  = 1'b0;
  endtask

  // Monitor: compares every write-word pop and every host read handshake against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (app_wr_next && wr_word_avail) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_word_unexpected: got 0x%0h/%0h expected none", app_wr_en_n, app_wr_data);
        end else
          chk("wr_word", {app_wr_en_n, app_wr_data}, wq.pop_front());
      end
      if (host_rd_valid && host_rd_ready) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_beat_unexpected: got 0x%0h expected none", host_rd_data);
        end else
          chk("rd_beat", {3'b0, host_rd_last, host_rd_data}, {3'b0, rq.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 required 1");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; host_width = 2'b10;
    host_wr_valid = 0; host_wr_data = 0; host_wr_en_n = 4'hF; app_wr_next = 0;
    app_rd_data = 0; app_rd_valid = 0; app_last_rd = 0; host_rd_ready = 0;
    #12;
    chk("rst_wr_ready", 36'(host_wr_ready), 36'd1);
    chk("rst_app_wr_data", 36'(app_wr_data), 36'd0);
    chk("rst_app_wr_en_n", 36'(app_wr_en_n), 36'hF);
    chk("rst_wr_avail", 36'(wr_word_avail), 36'd0);
    chk("rst_rd_valid", 36'(host_rd_valid), 36'd0);
    chk("rst_rd_data", 36'(host_rd_data), 36'd0);
    chk("rst_rd_last", 36'(host_rd_last), 36'd0);
    chk("rst_flags", {34'd0, wr_udf, rd_ovf}, 36'd0);
    @(posedge clk); #1; reset = 1'b0;
    step();

    // 8-bit packing with a disabled lane
    wr_beat(32'h11, 4'b0); wr_beat(32'h22, 4'b0); wr_beat(32'h33, 4'b1); wr_beat(32'h44, 4'b0);
    chk("w8_data", 36'(app_wr_data), 36'h44332211);
    chk("w8_en_n", 36'(app_wr_en_n), 36'h4);
    chk("w8_avail", 36'(wr_word_avail), 36'd1);
    wq.push_back({4'b0100, 32'h44332211});
    app_wr_next = 1'b1; step(); app_wr_next = 1'b0;
    chk("w8_avail_after_pop", 36'(wr_word_avail), 36'd0);

    // 16-bit back-pressure: two words fill the FIFO
    host_width = 2'b01; step();
    wr_beat(32'h0001, 4'h0); wr_beat(32'h0002, 4'h0);
    wr_beat(32'h0003, 4'h0); wr_beat(32'h0004, 4'h0);
    wq.push_back({4'h0, 32'h00020001});
    wq.push_back({4'h0, 32'h00040003});
    wq.push_back({4'h0, 32'h00060005});
    host_wr_valid = 1'b1; host_wr_data = 32'h0005; host_wr_en_n = 4'h0;
    step(); chk("w16_full_ready", 36'(host_wr_ready), 36'd0);
    step(); chk("w16_full_ready2", 36'(host_wr_ready), 36'd0);
    app_wr_next = 1'b1;
    chk("w16_ready_during_pop", 36'(host_wr_ready), 36'd0);
    step(); app_wr_next = 1'b0;
    chk("w16_ready_after_pop", 36'(host_wr_ready), 36'd1);
    wr_beat(32'h0005, 4'h0); wr_beat(32'h0006, 4'h0);
    app_wr_next = 1'b1; step(); step(); app_wr_next = 1'b0;
    chk("w16_drained", 36'(wr_word_avail), 36'd0);

    // underflow
    app_wr_next = 1'b1; step(); app_wr_next = 1'b0;
    chk("udf_flag", 36'(wr_udf), 36'd1);
    chk("udf_outputs", {app_wr_en_n, app_wr_data}, {4'hF, 32'h0});
    chk("udf_avail", 36'(wr_word_avail), 36'd0);

    // width switch discards a partial word
    host_width = 2'b10; step();
    wr_beat(32'hAA, 4'h0); wr_beat(32'hBB, 4'h0);
    host_width = 2'b01; step();
    host_width = 2'b10; step();
    chk("sw_no_word", 36'(wr_word_avail), 36'd0);
    wr_beat(32'h01, 4'h0); wr_beat(32'h02, 4'h0); wr_beat(32'h03, 4'h0); wr_beat(32'h04, 4'h0);
    wq.push_back({4'h0, 32'h04030201});
    app_wr_next = 1'b1; step(); app_wr_next = 1'b0;

    // 16-bit read unpacking
    host_width = 2'b01; host_rd_ready = 1'b1; step();
    rq.push_back({1'b0, 32'h5555}); rq.push_back({1'b0, 32'hAAAA});
    rq.push_back({1'b0, 32'hCCCC}); rq.push_back({1'b1, 32'hDDDD});
    rd_word(32'hAAAA5555, 1'b0);
    chk("rd_latency", 36'(host_rd_valid), 36'd1);
    rd_word(32'hDDDDCCCC, 1'b1);
    repeat (5) step();
    chk("rd_drained", 36'(host_rd_valid), 36'd0);

    // overflow: 9 words into an 8-deep FIFO with the host stalled
    host_width = 2'b00; host_rd_ready = 1'b0; step();
    for (int i = 0; i < 8; i++) begin
      rd_word(32'h10000000 + 32'(i), i == 7);
      rq.push_back({i == 7, 32'h10000000 + 32'(i)});
    end
    chk("ovf_not_yet", 36'(rd_ovf), 36'd0);
    rd_word(32'h10000008, 1'b1);
    chk("ovf_flag", 36'(rd_ovf), 36'd1);
    host_rd_ready = 1'b1;
    repeat (10) step();
    chk("ovf_drained", 36'(host_rd_valid), 36'd0);

    // reset mid read burst
    host_width = 2'b01; host_rd_ready = 1'b0; step();
    rd_word(32'h12345678, 1'b0); rd_word(32'h9ABCDEF0, 1'b1);
    chk("mid_valid_pre", 36'(host_rd_valid), 36'd1);
    #2 reset = 1'b1; #1;
    chk("mid_rst_rd", {2'b0, host_rd_valid, host_rd_last, host_rd_data}, 36'd0);
    chk("mid_rst_flags", {34'd0, wr_udf, rd_ovf}, 36'd0);
    chk("mid_rst_wr", {host_wr_ready, wr_word_avail, app_wr_en_n, app_wr_data[29:0]},
        {1'b1, 1'b0, 4'hF, 30'd0});
    step(); step(); reset = 1'b0; step();

    chk("wq_empty", 36'(wq.size()), 36'd0);
    chk("rq_empty", 36'(rq.size()), 36'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
